btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 153 +++++++++++++++
 tb/tb_btn_debounce.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw push-button, debounces it with a 4-state FSM and emits level/press/release.
// Long-press output hold_o is built only when BTN_DEBOUNCE_HOLD_EN is defined; otherwise it is tied low.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int HOLD_CYCLES     = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_REL_WAIT   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   w_s;
    logic                   w_cnt_last;
    logic                   w_rel_accept;

    // Synchroniser chain, preset to the released pin level so reset never looks like a press
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{REL_LVL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign w_s          = r_sync[SYNC_STAGES-1] ^ REL_LVL;
    assign w_cnt_last   = (r_cnt == CNT_LAST);
    assign w_rel_accept = (r_state == ST_REL_WAIT) && !w_s && w_cnt_last;

    // Debounce FSM with stability counter and registered level/pulse outputs
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end else if (w_cnt_last) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= CNT_ZERO;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!w_s) begin
                        r_state <= ST_REL_WAIT;
                        r_cnt   <= CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                    end
                end
                ST_REL_WAIT: begin
                    if (w_s) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= CNT_ZERO;
                    end else if (w_cnt_last) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= CNT_ZERO;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign level_o   = r_level;
    assign press_o   = r_press;
    assign release_o = r_release;

`ifdef BTN_DEBOUNCE_HOLD_EN
    localparam int            HW       = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic [HW-1:0] r_hold_cnt;
    logic          r_hold;

    // Long-press timer: runs through PRESSED and REL_WAIT, restarts for each new press, drops with release
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= {HW{1'b0}};
            r_hold     <= 1'b0;
        end else if ((r_state == ST_IDLE) || (r_state == ST_PRESS_WAIT) || w_rel_accept) begin
            r_hold_cnt <= {HW{1'b0}};
            r_hold     <= 1'b0;
        end else if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            r_hold     <= ((r_hold_cnt + HOLD_ONE) == HOLD_MAX);
        end else begin
            r_hold_cnt <= r_hold_cnt;
            r_hold     <= 1'b1;
        end
    end

    assign hold_o = r_hold;
`else
    // HOLD_CYCLES is referenced so the default build carries no dangling parameter
    localparam logic HOLD_CFG_OK = (HOLD_CYCLES > 0);
    assign hold_o = HOLD_CFG_OK & 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: expected pulses are queued with their cycle and checked by a negedge monitor.
module tb_btn_debounce;

    localparam int DC  = 8;
    localparam int SS  = 2;
    localparam int AL  = 1;
    localparam int HC  = 32;
    localparam int LAT = SS + DC;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_i;
    logic level_o, press_o, release_o, hold_o;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SS),
        .ACTIVE_LOW     (AL),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk_i    (clk),
        .rst_n    (rst_n),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .hold_o   (hold_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_cyc[$];
    bit exp_kind[$];
    bit mon_en = 1'b0;
    bit mon_level = 1'b0;
    int mon_pulses = 0;
    int mon_c;
    bit mon_k;

    bit model_en = 1'b0;
    bit m1, m2, ms, mlevel;
    int run;

    // Pulse scoreboard, exclusivity, alternation and level tracking
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            checks++;
            if (press_o === 1'b1 && release_o === 1'b1) begin
                errors++;
                $display("FAIL exclusive: press=%b release=%b at cycle %0d, required not both", press_o, release_o, cyc);
            end
            if (press_o === 1'b1 || release_o === 1'b1) begin
                mon_pulses++;
                checks++;
                if (exp_cyc.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: press=%b release=%b at cycle %0d, required none", press_o, release_o, cyc);
                end else begin
                    mon_c = exp_cyc.pop_front();
                    mon_k = exp_kind.pop_front();
                    if (mon_k !== press_o || mon_c != cyc) begin
                        errors++;
                        $display("FAIL pulse_timing: got press=%b at cycle %0d, required press=%b at cycle %0d", press_o, cyc, mon_k, mon_c);
                    end
                end
                checks++;
                if (press_o === mon_level) begin
                    errors++;
                    $display("FAIL alternation: press=%b with previous level %b at cycle %0d", press_o, mon_level, cyc);
                end
                mon_level = press_o;
            end
            checks++;
            if (level_o !== mon_level) begin
                errors++;
                $display("FAIL level_track: level_o=%b at cycle %0d, required %b", level_o, cyc, mon_level);
            end
`ifndef BTN_DEBOUNCE_HOLD_EN
            checks++;
            if (hold_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_tied: hold_o=%b at cycle %0d, required 0", hold_o, cyc);
            end
`endif
        end
    end

    // Run-length reference for the random test: a change is accepted after DC consecutive differing samples
    always @(posedge clk) begin
        if (model_en) begin
            ms = (AL != 0) ? ~m2 : m2;
            m2 = m1;
            m1 = btn_i;
            if (ms != mlevel) run++;
            else run = 0;
            if (run == DC) begin
                mlevel = ~mlevel;
                run = 0;
                exp_cyc.push_back(cyc + 1);
                exp_kind.push_back(mlevel);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        model_en = 1'b0;
        exp_cyc.delete();
        exp_kind.delete();
        mon_level = 1'b0;
        m1 = 1'b1; m2 = 1'b1; mlevel = 1'b0; run = 0;
    endtask

    task automatic test_reset();
        btn_i = 1'b1;
        enter_reset();
        #1;
        checks++;
        if ({level_o, press_o, release_o, hold_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: level/press/release/hold=%b, required 0000", {level_o, press_o, release_o, hold_o});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick_to(cyc + 20);
        checks++;
        if (level_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_level: level_o=%b, required 0", level_o);
        end
    endtask

    task automatic test_clean_press();
        int t;
        t = cyc;
        btn_i = 1'b0;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b1);
        tick_to(t + LAT - 1);
        checks++;
        if (level_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_early: level_o=%b one cycle before latency, required 0", level_o);
        end
        tick_to(t + LAT);
        checks++;
        if (level_o !== 1'b1 || press_o !== 1'b1) begin
            errors++;
            $display("FAIL clean_press: level=%b press=%b at latency, required 1 1", level_o, press_o);
        end
        tick_to(t + LAT + 4);
        checks++;
        if (exp_cyc.size() != 0 || release_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_drain: pending=%0d release=%b, required 0 0", exp_cyc.size(), release_o);
        end
        t = cyc;
        btn_i = 1'b1;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b0);
        tick_to(t + LAT + 4);
        checks++;
        if (exp_cyc.size() != 0 || level_o !== 1'b0) begin
            errors++;
            $display("FAIL clean_release: pending=%0d level=%b, required 0 0", exp_cyc.size(), level_o);
        end
    endtask

    task automatic test_bouncy_press();
        int t;
        for (int i = 0; i < 10; i++) begin
            btn_i = ~btn_i;
            tick_to(cyc + 3);
        end
        t = cyc;
        btn_i = 1'b0;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b1);
        tick_to(t + LAT - 1);
        checks++;
        if (level_o !== 1'b0 || mon_level !== 1'b0) begin
            errors++;
            $display("FAIL bouncy_early: level_o=%b before settle latency, required 0", level_o);
        end
        tick_to(t + LAT + 4);
        checks++;
        if (exp_cyc.size() != 0 || level_o !== 1'b1) begin
            errors++;
            $display("FAIL bouncy_press: pending=%0d level=%b, required 0 1", exp_cyc.size(), level_o);
        end
    endtask

    task automatic test_release_glitch();
        int t;
        btn_i = 1'b1;
        tick_to(cyc + 5);
        btn_i = 1'b0;
        tick_to(cyc + 15);
        checks++;
        if (level_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_reject: level_o=%b after 5-cycle release glitch, required 1", level_o);
        end
        t = cyc;
        btn_i = 1'b1;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b0);
        tick_to(t + 20);
        checks++;
        if (exp_cyc.size() != 0 || level_o !== 1'b0) begin
            errors++;
            $display("FAIL glitch_release: pending=%0d level=%b, required 0 0", exp_cyc.size(), level_o);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        t = cyc;
        btn_i = 1'b0;
        tick_to(t + 7);
        enter_reset();
        #1;
        checks++;
        if ({level_o, press_o, release_o, hold_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: level/press/release/hold=%b, required 0000", {level_o, press_o, release_o, hold_o});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = cyc;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b1);
        tick_to(t + LAT - 1);
        checks++;
        if (level_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early: level_o=%b before latency, required 0", level_o);
        end
        tick_to(t + LAT);
        checks++;
        if (press_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_press: press_o=%b at %0d cycles after reset, required 1", press_o, LAT);
        end
        tick_to(t + LAT + 4);
        t = cyc;
        btn_i = 1'b1;
        exp_cyc.push_back(t + LAT); exp_kind.push_back(1'b0);
        tick_to(t + LAT + 4);
        checks++;
        if (exp_cyc.size() != 0) begin
            errors++;
            $display("FAIL midreset_drain: pending=%0d, required 0", exp_cyc.size());
        end
    endtask

    task automatic test_hold();
        int t, p, r;
        bit hold_exp;
`ifdef BTN_DEBOUNCE_HOLD_EN
        hold_exp = 1'b1;
`else
        hold_exp = 1'b0;
`endif
        t = cyc;
        btn_i = 1'b0;
        p = t + LAT;
        exp_cyc.push_back(p); exp_kind.push_back(1'b1);
        tick_to(p + HC - 1);
        checks++;
        if (hold_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_early: hold_o=%b one cycle before hold time, required 0", hold_o);
        end
        tick_to(p + HC);
        checks++;
        if (hold_o !== hold_exp) begin
            errors++;
            $display("FAIL hold_rise: hold_o=%b at %0d cycles after press, required %b", hold_o, HC, hold_exp);
        end
        tick_to(t + 60);
        btn_i = 1'b1;
        r = cyc + LAT;
        exp_cyc.push_back(r); exp_kind.push_back(1'b0);
        tick_to(r - 1);
        checks++;
        if (hold_o !== hold_exp) begin
            errors++;
            $display("FAIL hold_keep: hold_o=%b one cycle before release, required %b", hold_o, hold_exp);
        end
        tick_to(r);
        checks++;
        if (hold_o !== 1'b0 || release_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_clear: hold=%b release=%b at release edge, required 0 1", hold_o, release_o);
        end
        tick_to(r + 4);
        checks++;
        if (exp_cyc.size() != 0) begin
            errors++;
            $display("FAIL hold_drain: pending=%0d, required 0", exp_cyc.size());
        end
    endtask

    task automatic test_random();
        int start, len, pulses0;
        btn_i = 1'b1;
        enter_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_en = 1'b1;
        pulses0 = mon_pulses;
        start = cyc;
        while (cyc < start + 1000) begin
            btn_i = ~btn_i;
            len = $urandom_range(20, 1);
            tick_to(cyc + len);
        end
        btn_i = 1'b1;
        tick_to(cyc + 30);
        model_en = 1'b0;
        checks++;
        if (exp_cyc.size() != 0) begin
            errors++;
            $display("FAIL random_drain: pending=%0d expected pulses not seen, required 0", exp_cyc.size());
        end
        checks++;
        if (mon_pulses == pulses0 || level_o !== 1'b0) begin
            errors++;
            $display("FAIL random_activity: pulses=%0d final level=%b, required >0 and 0", mon_pulses - pulses0, level_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_release_glitch();
        test_reset_mid();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
